// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: one-hot FSM states, the SPI mode and
// the default word width.
package spi_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Mode 0: sclk idles low, data is sampled on the rising edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LOAD   = 4'b0010,
        ST_SHIFT  = 4'b0100,
        ST_RELOAD = 4'b1000
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for an asynchronous pin, plus a third flop that
// provides single-cycle rise/fall pulses aligned with the synchronised level.
module spi_pin_sync #(
    parameter logic INIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg <= {3{INIT}};
        end else begin
            sync_reg <= {sync_reg[1:0], pin};
        end
    end

    assign level = sync_reg[1];
    assign rise  = sync_reg[1] & ~sync_reg[2];
    assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI mode-0 responder: oversamples ss_n/sclk/mosi on the system clock, emits
// received words as rx strobes and serves tx words from a valid/ready source.
module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ss_n,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             aborted
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    // ss_n idles high, so its synchroniser starts deasserted.
    spi_pin_sync #(.INIT(1'b1)) u_sync_ss (
        .clock(clock), .reset(reset), .pin(ss_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_pin_sync #(.INIT(1'b0)) u_sync_sclk (
        .clock(clock), .reset(reset), .pin(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.INIT(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .pin(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, ss_level, sclk_level, mosi_rise, mosi_fall};

    logic sample_edge, shift_edge;
    assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
    assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [WIDTH-1:0]  tx_shift;
    logic [WIDTH-1:0]  rx_shift;
    logic [WIDTH-1:0]  rx_next;
    logic [WIDTH-1:0]  load_word;

    assign rx_next   = {rx_shift[WIDTH-2:0], mosi_level};
    assign load_word = tx_valid ? tx_data : FILL;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            aborted  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    if (ss_fall) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        tx_shift <= load_word;
                        miso     <= load_word[WIDTH-1];
                        tx_ready <= tx_valid;
                        bit_cnt  <= '0;
                        miso_oe  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        // A word finishing on the deselect cycle still counts.
                        if (sample_edge && bit_cnt == LAST) begin
                            rx_shift <= rx_next;
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end else begin
                            aborted <= (bit_cnt != '0);
                        end
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            state    <= ST_RELOAD;
                        end
                    end else if (shift_edge) begin
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        miso     <= tx_shift[WIDTH-2];
                    end
                end
                ST_RELOAD: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (shift_edge) begin
                        // The falling edge after the last bit starts the next word.
                        tx_shift <= load_word;
                        miso     <= load_word[WIDTH-1];
                        tx_ready <= tx_valid;
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: a behavioural mode-0 master drives the pins
// and every check is an immediate assertion against hand-computed values.
module tb_spi_slave_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ss_n  = 1'b1;
    logic       sclk  = 1'b0;
    logic       mosi  = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, aborted;

    int tests = 0;
    int fails = 0;
    int n_txr = 0, n_rxv = 0, n_abt = 0;
    logic [7:0] last_rx = 8'h00;

    always #5 clock = ~clock;

    spi_slave_fsm #(.WIDTH(8), .FILL(8'h00)) dut (
        .clock(clock), .reset(reset), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .aborted(aborted)
    );

    always @(negedge clock) begin
        if (tx_ready === 1'b1) n_txr++;
        if (aborted === 1'b1) n_abt++;
        if (rx_valid === 1'b1) begin
            n_rxv++;
            last_rx = rx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends nbits MSB-first; each bit is a fall, a 6-clock low phase with
    // miso sampled at its end, then a rise and a 6-clock high phase.
    task automatic xfer_bits(input logic [7:0] mo, input int nbits, input bit coincide,
                             output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = mo[7-i];
            wait_clk(6);
            mi[7-i] = miso;
            sclk = 1'b1;
            if (coincide && i == nbits - 1) ss_n = 1'b1;
            wait_clk(6);
        end
    endtask

    task automatic end_xfer();
        ss_n = 1'b1;
        wait_clk(8);
        sclk = 1'b0;
        wait_clk(6);
    endtask

    logic [7:0] mi;
    int t0, r0, a0;

    initial begin
        #1;
        chk("reset_miso", miso, 0);
        chk("reset_miso_oe", miso_oe, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_busy", busy, 0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);

        // Single word, tx A5, master sends 3C.
        tx_valid = 1'b1; tx_data = 8'hA5;
        t0 = n_txr; r0 = n_rxv; a0 = n_abt;
        ss_n = 1'b0;
        xfer_bits(8'h3C, 8, 1'b0, mi);
        chk("t1_miso_oe", miso_oe, 1);
        end_xfer();
        $display("[TB] xfer1 miso=%h rx=%h", mi, last_rx);
        chk("t1_miso_bits", mi, 8'hA5);
        chk("t1_tx_ready_cnt", n_txr - t0, 1);
        chk("t1_rx_valid_cnt", n_rxv - r0, 1);
        chk("t1_rx_data", rx_data, 8'h3C);
        chk("t1_aborted_cnt", n_abt - a0, 0);
        chk("t1_miso_oe_idle", miso_oe, 0);

        // No tx word: FILL goes out, nothing consumed.
        tx_valid = 1'b0; tx_data = 8'hEE;
        t0 = n_txr; r0 = n_rxv;
        ss_n = 1'b0;
        xfer_bits(8'hFF, 8, 1'b0, mi);
        end_xfer();
        $display("[TB] xfer2 miso=%h rx=%h", mi, last_rx);
        chk("t2_miso_fill", mi, 8'h00);
        chk("t2_tx_ready_cnt", n_txr - t0, 0);
        chk("t2_rx_valid_cnt", n_rxv - r0, 1);
        chk("t2_rx_data", rx_data, 8'hFF);

        // Back-to-back words under one select.
        tx_valid = 1'b1; tx_data = 8'h12;
        t0 = n_txr; r0 = n_rxv;
        ss_n = 1'b0;
        xfer_bits(8'hC3, 8, 1'b0, mi);
        $display("[TB] xfer3a miso=%h rx=%h", mi, last_rx);
        chk("t3_miso_w0", mi, 8'h12);
        chk("t3_rx_w0", last_rx, 8'hC3);
        chk("t3_busy_pending", busy, 1);
        tx_data = 8'h34;
        xfer_bits(8'h81, 8, 1'b0, mi);
        end_xfer();
        $display("[TB] xfer3b miso=%h rx=%h", mi, last_rx);
        chk("t3_miso_w1", mi, 8'h34);
        chk("t3_rx_w1", rx_data, 8'h81);
        chk("t3_tx_ready_cnt", n_txr - t0, 2);
        chk("t3_rx_valid_cnt", n_rxv - r0, 2);

        // Abort after 5 bits.
        r0 = n_rxv; a0 = n_abt;
        ss_n = 1'b0;
        xfer_bits(8'hF0, 5, 1'b0, mi);
        ss_n = 1'b1;
        wait_clk(4);
        chk("t4_miso_oe_off", miso_oe, 0);
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(6);
        $display("[TB] abort aborted_cnt=%0d rx=%h", n_abt - a0, rx_data);
        chk("t4_aborted_cnt", n_abt - a0, 1);
        chk("t4_rx_valid_cnt", n_rxv - r0, 0);
        chk("t4_rx_data_held", rx_data, 8'h81);

        // Asynchronous reset mid-word, then a fresh transfer.
        ss_n = 1'b0;
        xfer_bits(8'hAA, 3, 1'b0, mi);
        chk("t5_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_miso_oe", miso_oe, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rx_data", rx_data, 0);
        chk("t5_rst_outputs", {miso, tx_ready, rx_valid, aborted}, 0);
        ss_n = 1'b1; sclk = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
        r0 = n_rxv; a0 = n_abt;
        tx_data = 8'h69;
        ss_n = 1'b0;
        xfer_bits(8'h5A, 8, 1'b0, mi);
        end_xfer();
        $display("[TB] xfer5 miso=%h rx=%h", mi, last_rx);
        chk("t5_rx_data", rx_data, 8'h5A);
        chk("t5_miso_bits", mi, 8'h69);
        chk("t5_rx_valid_cnt", n_rxv - r0, 1);
        chk("t5_aborted_cnt", n_abt - a0, 0);

        // ss_n rise lands on the same synced cycle as the 8th sclk rise.
        r0 = n_rxv; a0 = n_abt;
        ss_n = 1'b0;
        xfer_bits(8'h96, 8, 1'b1, mi);
        end_xfer();
        $display("[TB] xfer6 rx=%h aborted_cnt=%0d", rx_data, n_abt - a0);
        chk("t6_rx_valid_cnt", n_rxv - r0, 1);
        chk("t6_rx_data", rx_data, 8'h96);
        chk("t6_aborted_cnt", n_abt - a0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
